debug_tx_sequencer: RTL and testbench
=====================================

# debug_tx_sequencer

Sequences transmission of the packed pipeline debug snapshot to the byte-wide serial transmitter. On request it latches the full N-bit snapshot, halts the pipeline, and feeds the snapshot to the transmitter one byte at a time over a start/done handshake. When the last byte completes, it releases the pipeline and pulses `done`. It sits between the snapshot packer, the UART transmitter, and the pipeline's global enable.

## Interface
- `N`, 1208: snapshot width in bits; multiple of 8.
- `BYTES`, N/8 (151): derived byte count; not overridden independently.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `send_req`  in  1  transmission request; sampled only in IDLE.
- `snapshot`  in  N  packed debug vector (PC, instruction, control, registers, hazard signals).
- `tx_done`  in  1  one-cycle pulse from the transmitter when the current byte has been fully shifted out.
- `tx_start`  out  1  one-cycle pulse ordering the transmitter to send `tx_data`.
- `tx_data`  out  8  byte to transmit.
- `cpu_halt`  out  1  pipeline freeze; high for the whole transfer.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when the transfer completes.
- `byte_idx`  out  8  index of the byte in flight, 0..BYTES-1.

## Operation
- Latch register: N-bit `shreg`. Counter: `byte_idx`. FSM states: IDLE, SEND, WAIT, DONE.
- IDLE, `send_req`=1: load `shreg`<=`snapshot`, `byte_idx`<=0, and go to SEND. `send_req`=0: stay in IDLE.
- SEND: `tx_start`=1 for exactly this cycle, then go to WAIT.
- WAIT with `tx_done`=1:
  - `byte_idx`==BYTES-1: go to DONE.
  - Otherwise: shift `shreg` right by 8, increment `byte_idx`, and go to SEND.
- WAIT with `tx_done`=0: hold state.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `tx_data` = `shreg[7:0]` at all times. Byte order is little-endian: byte k = snapshot[8k+7:8k], so PC[7:0] is sent first and ForwardBE byte last.
- `cpu_halt` = `busy`. Both are high in SEND, WAIT and DONE, and low in IDLE.
- `snapshot` changes after the load cycle have no effect on the transfer in progress.
- `send_req` outside IDLE is ignored and not queued. A level still high on return to IDLE starts a new transfer.
- `tx_done` outside WAIT, including the SEND cycle itself, is ignored.
- `byte_idx` never exceeds BYTES-1; there is no wrap-around.
- Reset mid-transfer aborts it. There is no resume; the next request restarts at byte 0.

## Timing
- Reset values:
  - state IDLE
  - `shreg`=0, `tx_data`=8'h00, `byte_idx`=0
  - `tx_start`=0, `cpu_halt`=0, `busy`=0, `done`=0
- Outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.
- Request at edge t: `busy`/`cpu_halt`/`tx_start` high after edge t; `tx_data` = byte 0 in the same cycle.
- `tx_done` sampled at edge u in WAIT: the next `tx_start` and new `tx_data` appear after edge u.
- Minimum per-byte period is 2 cycles (SEND plus one WAIT cycle). This occurs when `tx_done` arrives in the first WAIT cycle.
- Minimum total transfer, request edge to `done` high, is 2*BYTES cycles (302 for N=1208). `busy` falls one cycle after `done`.
- `tx_data` is stable from `tx_start` until the `tx_done` edge.

## Test plan
- Reset: assert `rst_n`=0 mid-clock → all outputs 0 immediately, without waiting for a clock edge. Release, hold `send_req`=0 for 10 cycles → outputs remain 0.
- Full transfer: snapshot byte k = k mod 256, responder returns `tx_done` 1 cycle after `tx_start`.
  - Bytes received are 0x00..0x96 in order, 151 `tx_start` pulses.
  - `done` pulses once, 302 cycles after the request edge.
  - `cpu_halt` is high throughout the transfer.
- Slow transmitter: `tx_done` 10 cycles after each `tx_start`, with `snapshot` inverted after the load cycle.
  - Received bytes equal the originally latched values.
  - `tx_data` is constant through each WAIT.
- Ignored events:
  - Pulse `send_req` at byte 20 → no restart, single `done`.
  - Pulse `tx_done` in the same cycle as `tx_start` → ignored, so that byte still waits for a real `tx_done`.
- Reset during byte 50 → outputs reset and `byte_idx`=0. A new request sends byte 0 first, and all 151 bytes follow.
- Back-to-back: hold `send_req`=1 continuously → second transfer starts the cycle after `busy` falls; second snapshot latched at that point.

Source files
------------

// File: rtl/debug_tx_sequencer.sv
// debug_tx_sequencer
// Latches the packed pipeline debug snapshot on request, freezes the
// pipeline, and hands the snapshot to a byte-wide transmitter one byte at a
// time (least significant byte first) over a start/done handshake. Once the
// last byte has been shifted out it releases the pipeline and pulses done.
//
// All outputs are decoded from registered state, so nothing on the input
// side can ripple combinationally to the transmitter or the pipeline enable.

module debug_tx_sequencer #(
  parameter  int N     = 1208,
  localparam int BYTES = N / 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         send_req,
  input  logic [N-1:0] snapshot,
  input  logic         tx_done,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  output logic         cpu_halt,
  output logic         busy,
  output logic         done,
  output logic [7:0]   byte_idx
);

  // Index of the final byte; byte_idx stops here and never wraps.
  localparam logic [7:0] LAST_IDX = 8'(BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   shreg_reg, shreg_next;
  logic [N-1:0]   shreg_shifted;
  logic [7:0]     byte_idx_reg, byte_idx_next;

  // Byte-lane view of the right shift by 8: each lane takes the lane above,
  // the top lane is filled with zero. The low lane is always the byte the
  // transmitter currently sees.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      if (gi == BYTES - 1) begin : g_top
        assign shreg_shifted[8*gi +: 8] = 8'h00;
      end else begin : g_mid
        assign shreg_shifted[8*gi +: 8] = shreg_reg[8*(gi+1) +: 8];
      end
    end
  endgenerate

  // State, latched snapshot and byte counter; reset aborts any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      shreg_reg    <= '0;
      byte_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      shreg_reg    <= shreg_next;
      byte_idx_reg <= byte_idx_next;
    end
  end

  // Next-state logic and state-decoded strobes. send_req is only looked at
  // in IDLE and tx_done only in WAIT, so stray pulses elsewhere (including
  // a tx_done coinciding with tx_start) cannot advance the transfer.
  always_comb begin
    state_next    = state_reg;
    shreg_next    = shreg_reg;
    byte_idx_next = byte_idx_reg;
    tx_start      = 1'b0;
    done          = 1'b0;
    busy          = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (send_req) begin
          shreg_next    = snapshot;
          byte_idx_next = '0;
          state_next    = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_start   = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (byte_idx_reg == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            shreg_next    = shreg_shifted;
            byte_idx_next = byte_idx_reg + 8'd1;
            state_next    = ST_SEND;
          end
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The pipeline stays frozen for exactly as long as the sequencer is busy.
  assign cpu_halt = busy;
  assign tx_data  = shreg_reg[7:0];
  assign byte_idx = byte_idx_reg;

endmodule

// File: tb/tb_debug_tx_sequencer.sv
// Self-checking bench for debug_tx_sequencer: a table of transfer scenarios,
// hand-written reset-abort and back-to-back sequences, and randomized
// transfers with per-byte random transmitter latency. Expected byte stream
// and transfer length come from the little-endian byte rule and the
// per-byte period of (latency + 1) cycles.

module tb_debug_tx_sequencer;

  localparam int N     = 1208;
  localparam int BYTES = N / 8;

  logic         clk;
  logic         rst_n;
  logic         send_req;
  logic [N-1:0] snapshot;
  logic         tx_done;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         cpu_halt;
  logic         busy;
  logic         done;
  logic [7:0]   byte_idx;

  int errors;
  int checks;

  // Monitor counters, sampled on the falling edge.
  int run_len;
  int xfer_len;
  int start_cnt;
  int done_cnt;

  debug_tx_sequencer #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .send_req (send_req),
    .snapshot (snapshot),
    .tx_done  (tx_done),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .cpu_halt (cpu_halt),
    .busy     (busy),
    .done     (done),
    .byte_idx (byte_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Measures request-edge-to-done length and counts strobes from the DUT.
  always @(negedge clk) begin
    if (!busy) begin
      run_len = 0;
    end else if (done) begin
      xfer_len = run_len;
      done_cnt = done_cnt + 1;
    end else begin
      run_len = run_len + 1;
    end
    if (tx_start) start_cnt = start_cnt + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, ".tx_start"}, tx_start, 0);
    check({nm, ".busy"},     busy,     0);
    check({nm, ".cpu_halt"}, cpu_halt, 0);
    check({nm, ".done"},     done,     0);
    check({nm, ".byte_idx"}, byte_idx, 0);
    check({nm, ".tx_data"},  tx_data,  0);
  endtask

  function automatic logic [N-1:0] make_snap(input int pat);
    logic [N-1:0] s;
    s = '0;
    for (int k = 0; k < BYTES; k++) begin
      case (pat)
        0:       s[8*k +: 8] = 8'(k);
        1:       s[8*k +: 8] = 8'($urandom);
        default: s[8*k +: 8] = 8'((k * 37) ^ 8'h5A);
      endcase
    end
    return s;
  endfunction

  // One transfer. Called just after a rising edge with the DUT in IDLE.
  // lat_fix > 0 gives a fixed transmitter latency, 0 a random 1..4 per byte.
  // exp_len < 0 means use the model's sum of per-byte periods.
  task automatic run_xfer(input string name, input logic [N-1:0] snap, input int lat_fix,
                          input bit inv, input int req_at, input bit glitch, input bit hold,
                          input int abort_at, input int exp_len);
    int model_len;
    int lat;
    int err0;
    logic [7:0] eb;
    err0      = errors;
    model_len = 0;
    start_cnt = 0;
    done_cnt  = 0;
    xfer_len  = -1;
    snapshot  = snap;
    send_req  = 1'b1;
    @(posedge clk); #1;
    if (!hold) send_req = 1'b0;
    for (int k = 0; k < BYTES; k++) begin
      eb = snap[8*k +: 8];
      check("send.tx_start", tx_start, 1);
      check("send.tx_data",  tx_data,  eb);
      check("send.byte_idx", byte_idx, k);
      check("send.busy",     busy,     1);
      check("send.cpu_halt", cpu_halt, 1);
      check("send.done",     done,     0);
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("abort");
        @(posedge clk); #1;
        check_idle_outputs("abort_hold");
        rst_n = 1'b1;
        $display("xfer %s: aborted by reset at byte %0d errors_added=%0d", name, k, errors - err0);
        return;
      end
      if (k == 0 && inv) snapshot = ~snap;
      if (glitch) tx_done = 1'b1;
      if (k == req_at) send_req = 1'b1;
      lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
      model_len += lat + 1;
      for (int i = 1; i <= lat; i++) begin
        @(posedge clk); #1;
        tx_done = (i == lat);
        check("wait.tx_start", tx_start, 0);
        check("wait.tx_data",  tx_data,  eb);
        check("wait.byte_idx", byte_idx, k);
        check("wait.busy",     busy,     1);
        check("wait.cpu_halt", cpu_halt, 1);
        check("wait.done",     done,     0);
      end
      @(posedge clk); #1;
      tx_done = 1'b0;
      if (!hold) send_req = 1'b0;
    end
    check("fin.done",     done,     1);
    check("fin.busy",     busy,     1);
    check("fin.cpu_halt", cpu_halt, 1);
    check("fin.tx_start", tx_start, 0);
    @(posedge clk); #1;
    check("post.done",     done,     0);
    check("post.busy",     busy,     0);
    check("post.cpu_halt", cpu_halt, 0);
    check("post.tx_start", tx_start, 0);
    check("xfer_len",  xfer_len,  (exp_len >= 0) ? exp_len : model_len);
    check("start_cnt", start_cnt, BYTES);
    check("done_cnt",  done_cnt,  1);
    $display("xfer %s: len=%0d starts=%0d dones=%0d errors_added=%0d",
             name, xfer_len, start_cnt, done_cnt, errors - err0);
  endtask

  typedef struct {
    string name;
    int    pat;
    int    lat;
    bit    inv;
    int    req_at;
    bit    glitch;
    int    exp_len;
  } vec_t;

  vec_t tbl[4];
  logic [N-1:0] snap_b;

  initial begin
    errors = 0;
    checks = 0;
    run_len = 0;
    xfer_len = 0;
    start_cnt = 0;
    done_cnt = 0;

    // Fastest responder: 2 cycles per byte.
    tbl[0] = '{name: "full",        pat: 0, lat: 1,  inv: 1'b0, req_at: -1, glitch: 1'b0, exp_len: 302};
    // Slow transmitter with the source snapshot inverted after the load.
    tbl[1] = '{name: "slow_inv",    pat: 1, lat: 10, inv: 1'b1, req_at: -1, glitch: 1'b0, exp_len: 1661};
    // Request pulse mid-transfer must not restart or queue.
    tbl[2] = '{name: "req_ignored", pat: 2, lat: 2,  inv: 1'b0, req_at: 20, glitch: 1'b0, exp_len: 453};
    // tx_done coinciding with tx_start on every byte must be ignored.
    tbl[3] = '{name: "done_glitch", pat: 1, lat: 3,  inv: 1'b0, req_at: -1, glitch: 1'b1, exp_len: 604};

    rst_n    = 1'b0;
    send_req = 1'b0;
    tx_done  = 1'b0;
    snapshot = '0;
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("in_reset");
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check_idle_outputs("idle");
    end

    for (int v = 0; v < 4; v++) begin
      run_xfer(tbl[v].name, make_snap(tbl[v].pat), tbl[v].lat, tbl[v].inv,
               tbl[v].req_at, tbl[v].glitch, 1'b0, -1, tbl[v].exp_len);
      repeat (2) @(posedge clk);
      #1;
    end

    // Reset in the middle of byte 50, then a fresh transfer from byte 0.
    run_xfer("abort", make_snap(0), 1, 1'b0, -1, 1'b0, 1'b0, 50, -1);
    repeat (2) @(posedge clk);
    #1 check_idle_outputs("after_abort_idle");
    run_xfer("after_abort", make_snap(2), 1, 1'b0, -1, 1'b0, 1'b0, -1, 302);

    // Back-to-back with send_req held; the second snapshot appears only in
    // the single IDLE cycle between transfers.
    snap_b = make_snap(1);
    run_xfer("b2b_first", make_snap(0), 1, 1'b0, -1, 1'b0, 1'b1, -1, 302);
    snapshot = snap_b;
    run_xfer("b2b_second", snap_b, 1, 1'b0, -1, 1'b0, 1'b0, -1, 302);
    repeat (2) @(posedge clk);
    #1;

    // Randomized transfers: random data, random per-byte latency, random
    // stray requests and glitches; length taken from the model.
    for (int r = 0; r < 3; r++) begin
      run_xfer($sformatf("rand%0d", r), make_snap(1), 0, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, BYTES - 1)), 1'($urandom_range(0, 1)),
               1'b0, -1, -1);
      repeat (int'($urandom_range(1, 3))) @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
